trail_engine: RTL

TRAIL_ENGINE -- requirements
Module: trail_engine

---
 rtl/tron_pkg.sv | 30 +++
 rtl/trail_engine_if.sv | 27 ++
 rtl/fb_addr.sv | 15 +
 rtl/trail_engine.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/tron_pkg.sv
// Shared constants and enums for the trail engine and its framebuffer address path.
package tron_pkg;

  localparam int H_RES   = 640;
  localparam int V_RES   = 480;
  localparam int FB_SIZE = 307200;
  localparam int FB_AW   = 19;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_PLACE = 3'd2,
    S_RUN   = 3'd3,
    S_STEP  = 3'd4,
    S_CRASH = 3'd5
  } state_t;

  // Opposite heading: up<->down, right<->left.
  function automatic dir_t dir_reverse(dir_t d);
    return dir_t'(d ^ 2'd2);
  endfunction

endpackage

// File: rtl/trail_engine_if.sv
// Control inputs and framebuffer/status outputs of the trail engine.
interface trail_engine_if;
  import tron_pkg::*;

  logic             tick;
  logic             start;
  logic             dir_valid;
  logic [1:0]       dir_req;
  logic [FB_AW-1:0] wr_addr;
  logic             wr_data;
  logic             wr_en;
  logic [9:0]       head_x;
  logic [8:0]       head_y;
  logic             crashed;
  logic             busy;

  modport master (
    output tick, start, dir_valid, dir_req,
    input  wr_addr, wr_data, wr_en, head_x, head_y, crashed, busy
  );

  modport slave (
    input  tick, start, dir_valid, dir_req,
    output wr_addr, wr_data, wr_en, head_x, head_y, crashed, busy
  );

endinterface

// File: rtl/fb_addr.sv
// Combinational pixel (x,y) to linear framebuffer address, y*640+x built from shifts.
module fb_addr
  import tron_pkg::*;
(
  input  logic [9:0]       x,
  input  logic [8:0]       y,
  output logic [FB_AW-1:0] addr
);

  logic [FB_AW-1:0] y_w;

  assign y_w  = FB_AW'(y);
  assign addr = (y_w << 9) + (y_w << 7) + FB_AW'(x);

endmodule

// File: rtl/trail_engine.sv
// Light-cycle trail engine: clears the framebuffer, places the head, then draws one pixel per step.
// Optional TRON_WRAP_EN: screen edges wrap around instead of crashing.
//
// state   | meaning
// IDLE    | after reset, waiting for START
// CLEAR   | writing 0 to every framebuffer word, one per cycle
// PLACE   | head set to start position, start pixel written
// RUN     | waiting for TICK, collecting heading requests
// STEP    | head moved, new pixel written
// CRASH   | head left the screen, waiting for START
module trail_engine
  import tron_pkg::*;
#(
  parameter int         START_X   = 320,
  parameter int         START_Y   = 240,
  parameter logic [1:0] START_DIR = 2'd1,
  parameter int         CLEAR_LEN = FB_SIZE  // words cleared per round; the full frame by default
) (
  input  logic          clock,
  input  logic          reset_n,
  trail_engine_if.slave bus
);

  localparam logic [9:0]       SX         = 10'(START_X);
  localparam logic [8:0]       SY         = 9'(START_Y);
  localparam logic [9:0]       X_MAX      = 10'(H_RES - 1);
  localparam logic [8:0]       Y_MAX      = 9'(V_RES - 1);
  localparam logic [FB_AW-1:0] CLEAR_LAST = FB_AW'(CLEAR_LEN - 1);
`ifdef TRON_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  state_t           state, state_nxt;
  logic [9:0]       head_x, head_x_nxt;
  logic [8:0]       head_y, head_y_nxt;
  dir_t             heading, heading_nxt;
  dir_t             pend, pend_nxt;
  logic             pend_v, pend_v_nxt;
  logic [FB_AW-1:0] wr_addr, wr_addr_nxt;
  logic             wr_data, wr_data_nxt;
  logic             wr_en, wr_en_nxt;
  logic             crashed, crashed_nxt;
  logic             busy, busy_nxt;

  dir_t             req, eff_dir;
  logic             req_ok, off;
  logic [9:0]       nx, pos_x;
  logic [8:0]       ny, pos_y;
  logic [FB_AW-1:0] pos_addr;

  // Single address generator: start pixel while clearing, next head pixel otherwise.
  assign pos_x = (state == S_CLEAR) ? SX : nx;
  assign pos_y = (state == S_CLEAR) ? SY : ny;

  fb_addr u_fb_addr (
    .x    (pos_x),
    .y    (pos_y),
    .addr (pos_addr)
  );

  always_comb begin
    req     = dir_t'(bus.dir_req);
    req_ok  = bus.dir_valid && (req != dir_reverse(heading));
    eff_dir = heading;
    if (pend_v) eff_dir = pend;
    if (req_ok) eff_dir = req;

    nx  = head_x;
    ny  = head_y;
    off = 1'b0;
    case (eff_dir)
      DIR_UP: begin
        if (head_y == 9'd0) begin off = 1'b1; ny = Y_MAX; end
        else ny = head_y - 9'd1;
      end
      DIR_RIGHT: begin
        if (head_x == X_MAX) begin off = 1'b1; nx = 10'd0; end
        else nx = head_x + 10'd1;
      end
      DIR_DOWN: begin
        if (head_y == Y_MAX) begin off = 1'b1; ny = 9'd0; end
        else ny = head_y + 9'd1;
      end
      default: begin
        if (head_x == 10'd0) begin off = 1'b1; nx = X_MAX; end
        else nx = head_x - 10'd1;
      end
    endcase
  end

  always_comb begin
    state_nxt   = state;
    head_x_nxt  = head_x;
    head_y_nxt  = head_y;
    heading_nxt = heading;
    pend_nxt    = pend;
    pend_v_nxt  = pend_v;
    wr_addr_nxt = wr_addr;
    wr_data_nxt = 1'b0;
    wr_en_nxt   = 1'b0;

    case (state)
      S_IDLE, S_CRASH: begin
        if (bus.start) begin
          state_nxt   = S_CLEAR;
          wr_en_nxt   = 1'b1;
          wr_addr_nxt = '0;
        end
      end
      S_CLEAR: begin
        wr_en_nxt = 1'b1;
        if (wr_addr == CLEAR_LAST) begin
          state_nxt   = S_PLACE;
          wr_addr_nxt = pos_addr;
          wr_data_nxt = 1'b1;
          head_x_nxt  = SX;
          head_y_nxt  = SY;
          heading_nxt = dir_t'(START_DIR);
          pend_v_nxt  = 1'b0;
        end else begin
          wr_addr_nxt = wr_addr + 1'b1;
        end
      end
      S_PLACE: state_nxt = S_RUN;
      S_RUN: begin
        if (bus.start) begin
          state_nxt   = S_CLEAR;
          wr_en_nxt   = 1'b1;
          wr_addr_nxt = '0;
        end else if (bus.tick) begin
          pend_v_nxt = 1'b0;
          if (off && !WRAP) begin
            state_nxt = S_CRASH;
          end else begin
            state_nxt   = S_STEP;
            heading_nxt = eff_dir;
            head_x_nxt  = nx;
            head_y_nxt  = ny;
            wr_en_nxt   = 1'b1;
            wr_data_nxt = 1'b1;
            wr_addr_nxt = pos_addr;
          end
        end else if (req_ok) begin
          pend_nxt   = req;
          pend_v_nxt = 1'b1;
        end
      end
      S_STEP:  state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase

    crashed_nxt = (state_nxt == S_CRASH);
    busy_nxt    = (state_nxt == S_CLEAR) || (state_nxt == S_PLACE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      head_x  <= SX;
      head_y  <= SY;
      heading <= dir_t'(START_DIR);
      pend    <= DIR_UP;
      pend_v  <= 1'b0;
      wr_addr <= '0;
      wr_data <= 1'b0;
      wr_en   <= 1'b0;
      crashed <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      head_x  <= head_x_nxt;
      head_y  <= head_y_nxt;
      heading <= heading_nxt;
      pend    <= pend_nxt;
      pend_v  <= pend_v_nxt;
      wr_addr <= wr_addr_nxt;
      wr_data <= wr_data_nxt;
      wr_en   <= wr_en_nxt;
      crashed <= crashed_nxt;
      busy    <= busy_nxt;
    end
  end

  assign bus.wr_addr = wr_addr;
  assign bus.wr_data = wr_data;
  assign bus.wr_en   = wr_en;
  assign bus.head_x  = head_x;
  assign bus.head_y  = head_y;
  assign bus.crashed = crashed;
  assign bus.busy    = busy;

endmodule
